// File: rtl/wts_noise_pkg.sv
// rtl/wts_noise_pkg.sv - register map and sweep control types for the noise controller
package wts_noise_pkg;

  localparam logic [1:0] ADR_FR    = 2'd0;
  localparam logic [1:0] ADR_MASK  = 2'd1;
  localparam logic [1:0] ADR_SWEEP = 2'd2;
  localparam logic [1:0] ADR_CLR   = 2'd3;

  localparam int FR_W = 5;

  typedef struct packed {
    logic [3:0] rate;
    logic       wrap;
    logic       dir;
    logic       en;
  } sweep_ctrl_t;

  // Bit 3 of the sweep control byte is unused.
  function automatic sweep_ctrl_t decode_sweep(input logic [7:0] d);
    return {d[7:4], d[2:0]};
  endfunction

endpackage

// File: rtl/wts_noise_sweep.sv
// rtl/wts_noise_sweep.sv - sweep period counter with FR step and limit detection
module wts_noise_sweep
  import wts_noise_pkg::*;
#(
  parameter int SWEEP_UNIT = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            active,
  input  sweep_ctrl_t     ctrl,
  input  logic [FR_W-1:0] fr,
  input  logic            cnt_clr,
  output logic            step_valid,
  output logic [FR_W-1:0] next_fr,
  output logic            limit_hit
);

  localparam int CW = $clog2(16 * SWEEP_UNIT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic          tick;
  logic          at_limit;

  assign last     = CW'((int'(ctrl.rate) + 1) * SWEEP_UNIT - 1);
  assign tick     = active && ctrl.en && (cnt == last);
  assign at_limit = ctrl.dir ? (fr == '0) : (fr == '1);

  // Wrapping falls out of the natural modulo-32 add/subtract.
  assign next_fr    = ctrl.dir ? fr - FR_W'(1) : fr + FR_W'(1);
  assign step_valid = tick && !(at_limit && !ctrl.wrap);
  assign limit_hit  = tick && at_limit && !ctrl.wrap;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (cnt_clr || !ctrl.en) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= (cnt == last) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wts_noise_controller.sv
// rtl/wts_noise_controller.sv - shadowed noise registers committed on active pulses, with sweep arbitration
module wts_noise_controller
  import wts_noise_pkg::*;
#(
  parameter int NUM_CH     = 5,
  parameter int SWEEP_UNIT = 64
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              active,
  input  logic              wr,
  input  logic [1:0]        address,
  input  logic [7:0]        wdata,
  output logic              noise_enable,
  output logic [FR_W-1:0]   reg_fr,
  output logic [NUM_CH-1:0] ch_noise_mask,
  output logic              pending,
  output logic              sweep_done
);

  logic [FR_W-1:0]   shadow_fr;
  logic [NUM_CH-1:0] shadow_mask;
  sweep_ctrl_t       shadow_sweep;
  logic [2:0]        pend;
  sweep_ctrl_t       live_sweep;

  logic wr_fr, wr_mask, wr_sweep, wr_clr;
  logic commit_fr, commit_mask, commit_sweep;
  logic [FR_W-1:0]   new_fr;
  logic [NUM_CH-1:0] new_mask;
  sweep_ctrl_t       new_sweep;

  logic            step_valid;
  logic            limit_hit;
  logic [FR_W-1:0] next_fr;

  assign wr_fr    = wr && (address == ADR_FR);
  assign wr_mask  = wr && (address == ADR_MASK);
  assign wr_sweep = wr && (address == ADR_SWEEP);
  assign wr_clr   = wr && (address == ADR_CLR);

  // A write landing on the active clk bypasses the shadow so the same pulse commits it.
  assign new_fr    = wr_fr    ? wdata[FR_W-1:0]     : shadow_fr;
  assign new_mask  = wr_mask  ? wdata[NUM_CH-1:0]   : shadow_mask;
  assign new_sweep = wr_sweep ? decode_sweep(wdata) : shadow_sweep;

  assign commit_fr    = active && (pend[0] || wr_fr);
  assign commit_mask  = active && (pend[1] || wr_mask);
  assign commit_sweep = active && (pend[2] || wr_sweep);

  assign pending = |pend;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shadow_fr    <= '0;
      shadow_mask  <= '0;
      shadow_sweep <= '0;
      pend         <= '0;
    end else begin
      if (wr_fr)    shadow_fr    <= wdata[FR_W-1:0];
      if (wr_mask)  shadow_mask  <= wdata[NUM_CH-1:0];
      if (wr_sweep) shadow_sweep <= decode_sweep(wdata);
      pend <= active ? 3'b000 : (pend | {wr_sweep, wr_mask, wr_fr});
    end
  end

  wts_noise_sweep #(
    .SWEEP_UNIT(SWEEP_UNIT)
  ) u_sweep (
    .clk       (clk),
    .nreset    (nreset),
    .active    (active),
    .ctrl      (live_sweep),
    .fr        (reg_fr),
    .cnt_clr   (commit_sweep),
    .step_valid(step_valid),
    .next_fr   (next_fr),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      reg_fr        <= '0;
      ch_noise_mask <= '0;
      noise_enable  <= 1'b0;
      live_sweep    <= '0;
      sweep_done    <= 1'b0;
    end else begin
      // CPU value beats a coincident sweep step.
      if (commit_fr)       reg_fr <= new_fr;
      else if (step_valid) reg_fr <= next_fr;

      if (commit_mask) begin
        ch_noise_mask <= new_mask;
        noise_enable  <= |new_mask;
      end

      if (commit_sweep)   live_sweep    <= new_sweep;
      else if (limit_hit) live_sweep.en <= 1'b0;

      if (limit_hit)   sweep_done <= 1'b1;
      else if (wr_clr) sweep_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wts_noise_controller.sv
// tb/tb_wts_noise_controller.sv - table and scoreboard bench for wts_noise_controller
module tb_wts_noise_controller;

  logic       clk = 1'b0;
  logic       nreset;
  logic       active;
  logic       wr;
  logic [1:0] address;
  logic [7:0] wdata;
  logic       noise_enable;
  logic [4:0] reg_fr;
  logic [4:0] ch_noise_mask;
  logic       pending;
  logic       sweep_done;

  int errors = 0;
  int checks = 0;

  wts_noise_controller #(
    .NUM_CH    (5),
    .SWEEP_UNIT(64)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .active       (active),
    .wr           (wr),
    .address      (address),
    .wdata        (wdata),
    .noise_enable (noise_enable),
    .reg_fr       (reg_fr),
    .ch_noise_mask(ch_noise_mask),
    .pending      (pending),
    .sweep_done   (sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       act;
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
    logic       p;
    logic [4:0] fr;
    logic [4:0] mask;
    logic       en;
  } vec_t;

  typedef struct {
    string      nm;
    logic [4:0] fr;
    logic       done;
  } exp_t;

  vec_t vecs[$];
  vec_t vq[$];
  exp_t fq[$];

  function automatic vec_t mk(logic act, logic w, logic [1:0] a, logic [7:0] d,
                              logic p, logic [4:0] fr, logic [4:0] mask, logic en);
    vec_t v;
    v.act = act; v.w = w; v.a = a; v.d = d;
    v.p = p; v.fr = fr; v.mask = mask; v.en = en;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic act, input logic w, input logic [1:0] a, input logic [7:0] d);
    active = act; wr = w; address = a; wdata = d;
    @(posedge clk);
    #1;
    active = 1'b0; wr = 1'b0;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b0, 2'd0, 8'h00);
      repeat (5) cyc(1'b0, 1'b0, 2'd0, 8'h00);
    end
  endtask

  task automatic expect_fr(input string nm, input logic [4:0] fr, input logic done);
    exp_t e;
    e.nm = nm; e.fr = fr; e.done = done;
    fq.push_back(e);
  endtask

  task automatic check_fr();
    exp_t e;
    if (fq.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = fq.pop_front();
      chk({e.nm, "_fr"}, reg_fr, e.fr);
      chk({e.nm, "_done"}, sweep_done, e.done);
    end
  endtask

  initial begin
    vec_t v;
    vec_t e;
    nreset = 1'b0; active = 1'b0; wr = 1'b0; address = 2'd0; wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fr", reg_fr, 0);
    chk("rst_mask", ch_noise_mask, 0);
    chk("rst_en", noise_enable, 0);
    chk("rst_pending", pending, 0);
    chk("rst_done", sweep_done, 0);
    nreset = 1'b1;

    //         act   w     a  d      p  fr  mask  en
    vecs.push_back(mk(1'b0, 1'b1, 0, 8'h11, 1, 0,  0,  0));
    vecs.push_back(mk(1'b0, 1'b0, 0, 8'h00, 1, 0,  0,  0));
    vecs.push_back(mk(1'b1, 1'b0, 0, 8'h00, 0, 17, 0,  0));
    vecs.push_back(mk(1'b0, 1'b0, 0, 8'h00, 0, 17, 0,  0));
    vecs.push_back(mk(1'b1, 1'b1, 1, 8'h05, 0, 17, 5,  1));
    vecs.push_back(mk(1'b0, 1'b1, 1, 8'h00, 1, 17, 5,  1));
    vecs.push_back(mk(1'b0, 1'b0, 0, 8'h00, 1, 17, 5,  1));
    vecs.push_back(mk(1'b1, 1'b0, 0, 8'h00, 0, 17, 0,  0));
    vecs.push_back(mk(1'b0, 1'b1, 1, 8'hFF, 1, 17, 0,  0));
    vecs.push_back(mk(1'b1, 1'b0, 0, 8'h00, 0, 17, 31, 1));
    vecs.push_back(mk(1'b0, 1'b1, 0, 8'h03, 1, 17, 31, 1));
    vecs.push_back(mk(1'b0, 1'b1, 0, 8'h1F, 1, 17, 31, 1));
    vecs.push_back(mk(1'b1, 1'b0, 0, 8'h00, 0, 31, 31, 1));
    vecs.push_back(mk(1'b0, 1'b1, 3, 8'h00, 0, 31, 31, 1));

    foreach (vecs[i]) begin
      v = vecs[i];
      vq.push_back(v);
      cyc(v.act, v.w, v.a, v.d);
      e = vq.pop_front();
      chk($sformatf("vec%0d_pending", i), pending, e.p);
      chk($sformatf("vec%0d_fr", i), reg_fr, e.fr);
      chk($sformatf("vec%0d_mask", i), ch_noise_mask, e.mask);
      chk($sformatf("vec%0d_en", i), noise_enable, e.en);
    end

    // Sweep down, no wrap, R=0.
    cyc(1'b0, 1'b1, 2'd0, 8'd30);
    cyc(1'b1, 1'b1, 2'd2, 8'h03);
    repeat (5) cyc(1'b0, 1'b0, 2'd0, 8'h00);
    expect_fr("down_63", 30, 0); pulse(63); check_fr();
    expect_fr("down_64", 29, 0); pulse(1);  check_fr();
    expect_fr("down_128", 28, 0); pulse(64); check_fr();

    // Sweep up to the limit without wrap.
    cyc(1'b0, 1'b1, 2'd0, 8'd30);
    cyc(1'b1, 1'b1, 2'd2, 8'h01);
    repeat (5) cyc(1'b0, 1'b0, 2'd0, 8'h00);
    expect_fr("up_64", 31, 0); pulse(64); check_fr();
    expect_fr("up_limit", 31, 1); pulse(64); check_fr();
    expect_fr("up_stopped", 31, 1); pulse(64); check_fr();
    cyc(1'b0, 1'b1, 2'd3, 8'h00);
    expect_fr("done_clr", 31, 0); pulse(1); check_fr();

    // Sweep up with wrap, R=1.
    cyc(1'b0, 1'b1, 2'd0, 8'd31);
    cyc(1'b1, 1'b1, 2'd2, 8'h15);
    repeat (5) cyc(1'b0, 1'b0, 2'd0, 8'h00);
    expect_fr("wrap_127", 31, 0); pulse(127); check_fr();
    expect_fr("wrap_128", 0, 0);  pulse(1);   check_fr();
    expect_fr("wrap_256", 1, 0);  pulse(128); check_fr();

    // CPU write colliding with a sweep step.
    cyc(1'b1, 1'b1, 2'd2, 8'h03);
    repeat (5) cyc(1'b0, 1'b0, 2'd0, 8'h00);
    expect_fr("coll_pre", 1, 0); pulse(63); check_fr();
    cyc(1'b1, 1'b1, 2'd0, 8'h08);
    repeat (5) cyc(1'b0, 1'b0, 2'd0, 8'h00);
    expect_fr("coll_cpu", 8, 0);  check_fr();
    expect_fr("coll_63", 8, 0);   pulse(63); check_fr();
    expect_fr("coll_64", 7, 0);   pulse(1);  check_fr();

    // Reset mid-pending.
    cyc(1'b0, 1'b1, 2'd0, 8'h05);
    chk("prerst_pending", pending, 1);
    nreset = 1'b0;
    #2;
    chk("midrst_fr", reg_fr, 0);
    chk("midrst_mask", ch_noise_mask, 0);
    chk("midrst_en", noise_enable, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_done", sweep_done, 0);
    nreset = 1'b1;
    pulse(2);
    chk("postrst_fr", reg_fr, 0);
    chk("postrst_pending", pending, 0);
    chk("postrst_en", noise_enable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wts_noise_controller.md
Name: wts_noise_controller

Overview:
Register-side controller for the shared noise generator of the wave-table sound block. Accepts CPU writes for noise frequency, per-channel noise mask and an automatic frequency sweep, and commits them only on 3.579 MHz `active` pulses so the generator never sees a mid-tick change. Drives the generator's `enable` and `reg_fr` inputs and exports the channel mask to the mixer. Arbitrates between CPU writes and the sweep engine, which both update `reg_fr`.

Parameters:
NUM_CH, 5, number of sound channels that can route noise (1..8).
SWEEP_UNIT, 64, `active` pulses per sweep-rate unit (power of two, 1..256).

Ports:
clk  input  1  system clock (21.477 MHz).
nreset  input  1  asynchronous reset, active-low.
active  input  1  one-clk timing pulse, 1 in 6 clks.
wr  input  1  CPU write strobe, one clk per write.
address  input  2  register select.
wdata  input  8  write data.
noise_enable  output  1  to the generator's `enable` input.
reg_fr  output  5  to the generator's `reg_fr` input.
ch_noise_mask  output  NUM_CH  per-channel noise routing to the mixer.
pending  output  1  a shadow write awaits commit.
sweep_done  output  1  a sweep stopped at its limit; sticky.

Behaviour:
- Reset: all outputs 0; shadow registers 0; sweep counter 0; no pending flags. Reset asserted mid-operation clears everything immediately (asynchronous) and drops any pending write.
- Register map, written through `wr`:
  - addr 0: `wdata[4:0]` = FR.
  - addr 1: `wdata[NUM_CH-1:0]` = channel mask; upper bits ignored.
  - addr 2: sweep control. [0] sweep_en; [1] dir (0 up, 1 down); [2] wrap (1 wrap-around, 0 stop at limit); [7:4] rate R.
  - addr 3: write clears `sweep_done`; no other effect.
- Shadow capture: a write is stored in that address's shadow register and sets its pending bit in the same clk. A later write to the same address before commit overwrites the shadow (last write wins).
- Commit: on a clk with `active=1`, every pending shadow is copied to the live registers and its pending bit is cleared. Outputs change in the following clk. A `wr` coinciding with `active` is committed by that same pulse.
- `pending` = OR of the pending bits.
- `noise_enable` is registered and equals (live mask != 0). It updates in the same clk as `ch_noise_mask`.
- Sweep period: P = (R+1)*SWEEP_UNIT `active` pulses.
  - The counter increments only on `active` while live sweep_en=1.
  - When counter = P-1 on an `active` pulse: step FR by ±1 per dir, and reset the counter to 0.
  - Committing addr 2 resets the counter to 0.
  - Counter width: ceil(log2(16*SWEEP_UNIT)).
- Limits:
  - Up from 31 or down from 0, wrap=1: wraps (31→0, 0→31).
  - wrap=0: FR holds, live sweep_en clears, `sweep_done` sets.
- Arbitration: an addr-0 commit and a sweep step on the same `active` → CPU value wins, the step is discarded, and the counter resets to 0.
- `sweep_done` clear and set in the same cycle → set wins.
- With sweep_en=0, the counter holds at 0.
- Latency: `wr` → output worst case 7 clks (6-clk `active` spacing plus 1 registered stage).

Decomposition:
- Package `wts_noise_pkg`:
  - address constants ADR_FR=0, ADR_MASK=1, ADR_SWEEP=2, ADR_CLR=3.
  - FR_W=5.
  - typedef `sweep_ctrl_t` as a packed struct {rate[3:0], wrap, dir, en}.
- Sub-module `wts_noise_sweep`:
  - holds the period counter and step/limit logic.
  - inputs: active, live sweep ctrl, current FR, counter-clear.
  - outputs: step_valid, next_fr, limit_hit.
- The top holds the shadows, commit logic, arbitration and output registers.

Test Plan:
1. Reset release; write addr0=0x11 between `active` pulses → `pending`=1 until the next `active`; `reg_fr`=17 one clk after that pulse; `noise_enable` stays 0.
2. Write addr1=0x05 in the exact clk `active`=1 → `ch_noise_mask`=5'b00101 and `noise_enable`=1 on the next clk. Then write addr1=0x00 → `noise_enable`=0 after the next `active`.
3. FR=30, addr2=0x03 (en, down, no wrap, R=0) → FR 29 after 64 `active` pulses and 28 after 128. Repeat with up from FR=30, wrap=0 → 31, then `sweep_done`=1, FR stays 31, sweep stops. Write addr3 → `sweep_done`=0.
4. FR=31, up, wrap=1, R=1 → FR=0 after 128 pulses, then 1 after 128 more; `sweep_done` stays 0.
5. Collision: arrange addr0=0x08 written so its commit lands on a sweep-step pulse → `reg_fr`=8 (not the stepped value), and the next step occurs exactly P pulses later.
6. Two writes to addr0 (0x03 then 0x1F) within one `active` gap → only 31 appears. Assert nreset mid-pending → all outputs 0, and no commit after release.
